// File: rtl/time_keeper.sv
// time_keeper: 24-hour clock with a button/crown setting interface.
//
// A prescaler divides clk down to a one-second tick. In RUN the time counts.
// A button event (a rising edge of B_L while En=1) either clears the time,
// when crown bit 9 is set, or steps through SET_H -> SET_M -> SET_S -> RUN.
// While in a set state with En=1, the selected field tracks the crown value
// on every cycle.
//
// Ports:
//   clk             - single clock; all state changes on its rising edge
//   rst             - synchronous active-high reset
//   En              - time mode selected; gates the button and the crown load
//   B_L             - set button, level
//   potentiometer_10- crown value: [9] selects clear, [8:0] is the set value
//   hour_10..sec_1  - BCD digits of the current time
//   daysignal       - one-cycle pulse after the midnight rollover
//   set_state       - current state (00 RUN, 01 SET_H, 10 SET_M, 11 SET_S)
module time_keeper #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic       B_L,
  input  logic [9:0] potentiometer_10,
  output logic [3:0] hour_10,
  output logic [3:0] hour_1,
  output logic [3:0] min_10,
  output logic [3:0] min_1,
  output logic [3:0] sec_10,
  output logic [3:0] sec_1,
  output logic       daysignal,
  output logic [1:0] set_state
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StSetH = 2'b01,
    StSetM = 2'b10,
    StSetS = 2'b11
  } state_e;

  state_e        state_q;
  logic [4:0]    hour_q;
  logic [5:0]    minute_q;
  logic [5:0]    second_q;
  logic [PW-1:0] presc_q;
  logic          b_l_q;
  logic          day_q;

  logic       btn_evt;
  logic       tick;
  logic [8:0] hour_div;
  logic [8:0] ms_div;
  logic [4:0] hour_set;
  logic [5:0] ms_set;

  assign btn_evt = B_L & ~b_l_q & En;
  assign tick    = (state_q == StRun) && (presc_q == PreMax);

  // Crown value scaled to the field range and clamped to its maximum.
  always_comb begin
    hour_div = potentiometer_10[8:0] / 9'd21;
    ms_div   = potentiometer_10[8:0] >> 3;
    hour_set = (hour_div > 9'd23) ? 5'd23 : hour_div[4:0];
    ms_set   = (ms_div > 9'd59) ? 6'd59 : ms_div[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      presc_q  <= '0;
      b_l_q    <= 1'b0;
      day_q    <= 1'b0;
    end else begin
      b_l_q <= B_L;
      day_q <= 1'b0;
      if (btn_evt) begin
        // A button event outranks a coincident tick; the tick is dropped.
        if (potentiometer_10[9]) begin
          state_q  <= StRun;
          hour_q   <= '0;
          minute_q <= '0;
          second_q <= '0;
          presc_q  <= '0;
        end else begin
          unique case (state_q)
            StRun:  state_q <= StSetH;
            StSetH: state_q <= StSetM;
            StSetM: state_q <= StSetS;
            StSetS: begin
              state_q <= StRun;
              presc_q <= '0;  // first tick a full second after setting
            end
            default: state_q <= StRun;
          endcase
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (tick) begin
              presc_q <= '0;
              if (second_q == 6'd59) begin
                second_q <= '0;
                if (minute_q == 6'd59) begin
                  minute_q <= '0;
                  if (hour_q == 5'd23) begin
                    hour_q <= '0;
                    day_q  <= 1'b1;
                  end else begin
                    hour_q <= hour_q + 5'd1;
                  end
                end else begin
                  minute_q <= minute_q + 6'd1;
                end
              end else begin
                second_q <= second_q + 6'd1;
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          StSetH:  if (En) hour_q   <= hour_set;
          StSetM:  if (En) minute_q <= ms_set;
          StSetS:  if (En) second_q <= ms_set;
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign hour_10   = 4'(hour_q / 5'd10);
  assign hour_1    = 4'(hour_q % 5'd10);
  assign min_10    = 4'(minute_q / 6'd10);
  assign min_1     = 4'(minute_q % 6'd10);
  assign sec_10    = 4'(second_q / 6'd10);
  assign sec_1     = 4'(second_q % 6'd10);
  assign daysignal = day_q;
  assign set_state = state_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_HZ=4 (a tick every 4 cycles).
module tb_time_keeper;

  localparam int unsigned CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic       B_L;
  logic [9:0] pot;
  logic [3:0] hour_10, hour_1, min_10, min_1, sec_10, sec_1;
  logic       daysignal;
  logic [1:0] set_state;
  logic [23:0] disp;

  int n_cmp = 0;
  int n_bad = 0;
  int day_hits = 0;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk             (clk),
    .rst             (rst),
    .En              (En),
    .B_L             (B_L),
    .potentiometer_10(pot),
    .hour_10         (hour_10),
    .hour_1          (hour_1),
    .min_10          (min_10),
    .min_1           (min_1),
    .sec_10          (sec_10),
    .sec_1           (sec_1),
    .daysignal       (daysignal),
    .set_state       (set_state)
  );

  always #5 clk = ~clk;

  // Packed BCD digits, so 23:59:59 reads as 24'h235959.
  assign disp = {hour_10, hour_1, min_10, min_1, sec_10, sec_1};

  // Advance n edges; inputs and outputs settle 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (daysignal === 1'b1) day_hits++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    En = 1'b1; B_L = 1'b0; pot = '0;
    do_reset();
    n_cmp++;
    if (disp !== 24'h000000) begin
      n_bad++; $display("FAIL reset_time: got %h want 000000", disp);
    end
    n_cmp++;
    if (set_state !== 2'b00) begin
      n_bad++; $display("FAIL reset_state: got %b want 00", set_state);
    end
    n_cmp++;
    if (daysignal !== 1'b0) begin
      n_bad++; $display("FAIL reset_day: got %b want 0", daysignal);
    end
  endtask

  task automatic test_run_minute();
    day_hits = 0;
    step(240);
    n_cmp++;
    if (disp !== 24'h000100) begin
      n_bad++; $display("FAIL run_minute: got %h want 000100", disp);
    end
    n_cmp++;
    if (day_hits !== 0) begin
      n_bad++; $display("FAIL run_minute_day: got %0d pulses want 0", day_hits);
    end
  endtask

  task automatic test_set_wrap();
    pot = 10'd500; B_L = 1'b1; step(1);
    B_L = 1'b0; step(1);
    n_cmp++;
    if (set_state !== 2'b01 || {hour_10, hour_1} !== 8'h23) begin
      n_bad++; $display("FAIL set_hour: got %b/%h want 01/23", set_state, {hour_10, hour_1});
    end
    pot = 10'd480; B_L = 1'b1; step(1);
    B_L = 1'b0; step(1);
    n_cmp++;
    if (set_state !== 2'b10 || {min_10, min_1} !== 8'h59) begin
      n_bad++; $display("FAIL set_min_clamp: got %b/%h want 10/59", set_state, {min_10, min_1});
    end
    pot = 10'd472; B_L = 1'b1; step(1);
    B_L = 1'b0; step(1);
    n_cmp++;
    if (set_state !== 2'b11 || {sec_10, sec_1} !== 8'h59) begin
      n_bad++; $display("FAIL set_sec: got %b/%h want 11/59", set_state, {sec_10, sec_1});
    end
    B_L = 1'b1; step(1);
    B_L = 1'b0;
    n_cmp++;
    if (set_state !== 2'b00 || disp !== 24'h235959) begin
      n_bad++; $display("FAIL set_done: got %b/%h want 00/235959", set_state, disp);
    end
    day_hits = 0;
    step(3);
    n_cmp++;
    if (disp !== 24'h235959 || day_hits !== 0) begin
      n_bad++; $display("FAIL pre_wrap: got %h/%0d want 235959/0", disp, day_hits);
    end
    step(1);
    n_cmp++;
    if (disp !== 24'h000000 || daysignal !== 1'b1) begin
      n_bad++; $display("FAIL midnight: got %h/%b want 000000/1", disp, daysignal);
    end
    step(1);
    n_cmp++;
    if (daysignal !== 1'b0 || day_hits !== 1) begin
      n_bad++; $display("FAIL day_pulse: got %b/%0d want 0/1", daysignal, day_hits);
    end
  endtask

  task automatic test_pot_reset();
    pot = 10'd252; B_L = 1'b1; step(1); B_L = 1'b0; step(1);
    pot = 10'd272; B_L = 1'b1; step(1); B_L = 1'b0; step(1);
    pot = 10'd448; B_L = 1'b1; step(1); B_L = 1'b0; step(1);
    B_L = 1'b1; step(1); B_L = 1'b0;
    n_cmp++;
    if (disp !== 24'h123456 || set_state !== 2'b00) begin
      n_bad++; $display("FAIL set_123456: got %h/%b want 123456/00", disp, set_state);
    end
    step(1);
    day_hits = 0;
    pot = 10'h200; B_L = 1'b1; step(1); B_L = 1'b0;
    n_cmp++;
    if (disp !== 24'h000000 || set_state !== 2'b00 || day_hits !== 0) begin
      n_bad++;
      $display("FAIL pot_clear: got %h/%b/%0d want 000000/00/0", disp, set_state, day_hits);
    end
    step(1);
  endtask

  task automatic test_held_button();
    pot = '0; En = 1'b1; B_L = 1'b1;
    step(10);
    n_cmp++;
    if (set_state !== 2'b01) begin
      n_bad++; $display("FAIL held_en1: got %b want 01", set_state);
    end
    B_L = 1'b0; step(1);
    pot = 10'h200; B_L = 1'b1; step(1); B_L = 1'b0; step(1);
    pot = '0;
    En = 1'b0; B_L = 1'b1;
    step(10);
    n_cmp++;
    if (set_state !== 2'b00) begin
      n_bad++; $display("FAIL held_en0: got %b want 00", set_state);
    end
    B_L = 1'b0; step(1);
    En = 1'b1;
  endtask

  task automatic test_back_to_back();
    // Control: an undisturbed tick lands on the 4th edge after reset.
    pot = '0; B_L = 1'b0;
    do_reset();
    step(4);
    n_cmp++;
    if (disp !== 24'h000001) begin
      n_bad++; $display("FAIL tick_phase: got %h want 000001", disp);
    end
    do_reset();
    step(3);
    B_L = 1'b1; step(1); B_L = 1'b0;
    n_cmp++;
    if (set_state !== 2'b01 || disp !== 24'h000000) begin
      n_bad++; $display("FAIL tick_collide: got %b/%h want 01/000000", set_state, disp);
    end
    step(1);
    pot = 10'd511; step(1);
    n_cmp++;
    if ({hour_10, hour_1} !== 8'h23) begin
      n_bad++; $display("FAIL hour_clamp: got %h want 23", {hour_10, hour_1});
    end
    pot = 10'd80; B_L = 1'b1; step(1); B_L = 1'b0; step(1);
    n_cmp++;
    if (set_state !== 2'b10 || {min_10, min_1} !== 8'h10) begin
      n_bad++; $display("FAIL set_m10: got %b/%h want 10/10", set_state, {min_10, min_1});
    end
    // En=0 in a set state: field and state hold, button ignored.
    En = 1'b0; pot = 10'd200; B_L = 1'b1; step(2); B_L = 1'b0;
    n_cmp++;
    if (set_state !== 2'b10 || {min_10, min_1} !== 8'h10) begin
      n_bad++; $display("FAIL en0_hold: got %b/%h want 10/10", set_state, {min_10, min_1});
    end
    En = 1'b1;
    day_hits = 0;
    rst = 1'b1; step(1); rst = 1'b0;
    n_cmp++;
    if (set_state !== 2'b00 || disp !== 24'h000000 || day_hits !== 0) begin
      n_bad++;
      $display("FAIL rst_in_setm: got %b/%h/%0d want 00/000000/0", set_state, disp, day_hits);
    end
  endtask

  initial begin
    rst = 1'b0; En = 1'b1; B_L = 1'b0; pot = '0;
    test_reset();
    test_run_minute();
    test_set_wrap();
    test_pot_reset();
    test_held_button();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
